// File: rtl/add_tc_pipe.sv
// Multi-lane two-stage pipelined two's-complement add/sub/accumulate/load unit
// with optional saturation, per-lane overflow flags and valid/ready flow control.
module add_tc_pipe #(
    parameter int W     = 8,
    parameter int LANES = 4,
    parameter int SAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           mode,
    input  logic [LANES*W-1:0]   in_a,
    input  logic [LANES*W-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_sum,
    output logic [LANES-1:0]     out_ovf
);

    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic                 s1_valid;
    logic [1:0]           s1_mode;
    logic [LANES*W-1:0]   s1_a;
    logic [LANES*W-1:0]   s1_b;
    logic [W-1:0]         acc [LANES];
    logic                 adv2;
    logic [LANES*W-1:0]   nxt_sum;
    logic [LANES-1:0]     nxt_ovf;

    // Raw result in W+1 bits; wide enough for every mode including -(-2^(W-1)).
    function automatic logic [W:0] lane_res(input logic [1:0] m,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W-1:0] c);
        logic [W:0] ea;
        logic [W:0] eb;
        logic [W:0] ec;
        logic [W:0] r;
        ea = {a[W-1], a};
        eb = {b[W-1], b};
        ec = {c[W-1], c};
        case (m)
            2'b00:   r = ea + eb;
            2'b01:   r = ea - eb;
            2'b10:   r = ec + ea;
            default: r = ea;
        endcase
        return r;
    endfunction

    assign adv2     = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | adv2;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [W:0] r;
        logic       ovf;
        assign r          = lane_res(s1_mode, s1_a[g*W +: W], s1_b[g*W +: W], acc[g]);
        assign ovf        = r[W] ^ r[W-1];
        assign nxt_ovf[g] = ovf;
        assign nxt_sum[g*W +: W] = (ovf && (SAT != 0)) ? (r[W] ? MINV : MAXV) : r[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_mode   <= 2'b00;
            s1_a      <= '0;
            s1_b      <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_mode <= mode;
                    s1_a    <= in_a;
                    s1_b    <= in_b;
                end
            end
            if (adv2) begin
                out_valid <= 1'b1;
                out_sum   <= nxt_sum;
                out_ovf   <= nxt_ovf;
                // Modes 10 and 11 both write back the stage-2 result (load's result is a).
                if (s1_mode[1]) begin
                    for (int i = 0; i < LANES; i++) begin
                        acc[i] <= nxt_sum[i*W +: W];
                    end
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_add_tc_pipe.sv
// Directed bench for add_tc_pipe: a saturating and a wrapping instance share stimulus.
module tb_add_tc_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;

    logic        in_ready, out_valid, in_ready_w, out_valid_w;
    logic [31:0] out_sum, out_sum_w;
    logic [3:0]  out_ovf, out_ovf_w;

    int n_tests = 0;
    int n_fail  = 0;

    add_tc_pipe #(.W(8), .LANES(4), .SAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf));

    add_tc_pipe #(.W(8), .LANES(4), .SAT(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .mode(mode), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_sum(out_sum_w), .out_ovf(out_ovf_w));

    always #5 clk = ~clk;

    function automatic logic [31:0] pack4(int x0, int x1, int x2, int x3);
        return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
    endfunction

    function automatic logic [31:0] all4(int x);
        return pack4(x, x, x, x);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task cyc;
        @(posedge clk);
        #1;
    endtask

    task send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        mode     = m;
        in_a     = a;
        in_b     = b;
    endtask

    int          ta [8][4];
    int          tb_v [8][4];
    logic [31:0] sa [8];
    logic [31:0] sb [8];
    logic [31:0] es [8];
    logic [3:0]  eo [8];
    int          ls [4];

    initial begin
        int tx, rx, s;
        logic stalled, saw_block;
        logic [31:0] held_sum;
        logic [3:0]  held_ovf;

        // reset state
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst_n = 1'b1;
        cyc;

        // add with saturation on lanes 2 and 3
        send(2'b00, pack4(10, -5, 127, -128), pack4(20, -7, 1, -1));
        cyc;
        in_valid = 1'b0;
        chk("add_lat1_valid", out_valid, 0);
        cyc;
        chk("add_valid", out_valid, 1);
        chk("add_sum", out_sum, pack4(30, -12, 127, -128));
        chk("add_ovf", out_ovf, 4'b1100);

        // subtract, saturating and wrapping
        send(2'b01, pack4(-128, 0, 100, 5), pack4(1, -128, -100, 5));
        cyc;
        in_valid = 1'b0;
        cyc;
        chk("sub_sum_sat", out_sum, pack4(-128, 127, 127, 0));
        chk("sub_ovf_sat", out_ovf, 4'b0111);
        chk("sub_sum_wrap", out_sum_w, pack4(127, -128, -56, 0));
        chk("sub_ovf_wrap", out_ovf_w, 4'b0111);

        // load then three back-to-back accumulates
        send(2'b11, all4(100), all4(0));
        cyc;
        send(2'b10, all4(20), all4(0));
        cyc;
        chk("load_sum", out_sum, all4(100));
        chk("load_ovf", out_ovf, 0);
        cyc;
        chk("acc1_sum", out_sum, all4(120));
        chk("acc1_ovf", out_ovf, 0);
        cyc;
        in_valid = 1'b0;
        chk("acc2_sum", out_sum, all4(127));
        chk("acc2_ovf", out_ovf, 4'b1111);
        cyc;
        chk("acc3_sum", out_sum, all4(127));
        chk("acc3_ovf", out_ovf, 4'b1111);
        chk("acc3_valid", out_valid, 1);
        send(2'b00, all4(1), all4(1));
        cyc;
        send(2'b10, all4(-27), all4(0));
        cyc;
        in_valid = 1'b0;
        chk("add_mid_sum", out_sum, all4(2));
        cyc;
        chk("acc_neg_sum", out_sum, all4(100));
        chk("acc_neg_ovf", out_ovf, 0);
        cyc;

        // streaming adds under out_ready pattern 1,0,0,1
        for (int k = 0; k < 8; k++) begin
            ta[k][0] = k * 16;   tb_v[k][0] = k * 3;
            ta[k][1] = -k * 15;  tb_v[k][1] = -20;
            ta[k][2] = 120;      tb_v[k][2] = 2 * k;
            ta[k][3] = -100 + k; tb_v[k][3] = -5 * k;
            eo[k] = 4'b0000;
            for (int l = 0; l < 4; l++) begin
                s = ta[k][l] + tb_v[k][l];
                if (s > 127) begin ls[l] = 127; eo[k][l] = 1'b1; end
                else if (s < -128) begin ls[l] = -128; eo[k][l] = 1'b1; end
                else ls[l] = s;
            end
            sa[k] = pack4(ta[k][0], ta[k][1], ta[k][2], ta[k][3]);
            sb[k] = pack4(tb_v[k][0], tb_v[k][1], tb_v[k][2], tb_v[k][3]);
            es[k] = pack4(ls[0], ls[1], ls[2], ls[3]);
        end
        tx = 0; rx = 0; stalled = 1'b0; saw_block = 1'b0;
        held_sum = '0; held_ovf = '0;
        for (int t = 0; t < 60 && rx < 8; t++) begin
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", out_sum, held_sum);
                chk("hold_ovf", out_ovf, held_ovf);
            end
            in_valid = (tx < 8);
            if (tx < 8) begin
                mode = 2'b00;
                in_a = sa[tx];
                in_b = sb[tx];
            end
            out_ready = (t % 4 == 0) || (t % 4 == 3);
            #1;
            if (!in_ready) saw_block = 1'b1;
            stalled  = out_valid && !out_ready;
            held_sum = out_sum;
            held_ovf = out_ovf;
            if (out_valid && out_ready) begin
                chk("stream_sum", out_sum, es[rx]);
                chk("stream_ovf", out_ovf, eo[rx]);
                rx++;
            end
            if (in_valid && in_ready) tx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", rx, 8);
        chk("stream_blocked", saw_block, 1);
        cyc;
        chk("stream_nodup", out_valid, 0);

        // accumulate held in stage 1 behind a stalled output
        send(2'b11, all4(10), all4(0));
        cyc;
        in_valid = 1'b0;
        cyc;
        chk("stall_load_sum", out_sum, all4(10));
        out_ready = 1'b0;
        send(2'b10, all4(5), all4(0));
        cyc;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_sum", out_sum, all4(10));
            chk("stall_in_ready", in_ready, 0);
            cyc;
        end
        out_ready = 1'b1;
        cyc;
        chk("stall_rel_sum", out_sum, all4(15));
        chk("stall_rel_valid", out_valid, 1);
        cyc;
        chk("stall_drain_valid", out_valid, 0);
        send(2'b10, all4(1), all4(0));
        cyc;
        in_valid = 1'b0;
        cyc;
        chk("stall_once_sum", out_sum, all4(16));

        // reset with two transactions in flight
        send(2'b00, all4(1), all4(2));
        cyc;
        send(2'b00, all4(4), all4(4));
        cyc;
        in_valid = 1'b0;
        chk("inflight_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_sum", out_sum, 0);
        chk("async_rst_valid_w", out_valid_w, 0);
        cyc;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc;
            chk("post_rst_idle", out_valid, 0);
        end
        send(2'b10, all4(3), all4(0));
        cyc;
        in_valid = 1'b0;
        cyc;
        chk("post_rst_acc", out_sum, all4(3));
        chk("post_rst_acc_w", out_sum_w, all4(3));
        chk("post_rst_valid", out_valid, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
